// File: rtl/primogen_param.sv
// Ascending prime generator with go/load handshake and configurable result width.
// Primality is decided by trial division with odd divisors through a shift-subtract divider.
module primogen_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned SW = 2 * WIDTH + 2;

  localparam logic [WIDTH:0]   C_ONE   = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0]   C_TWO   = (WIDTH + 1)'(2);
  localparam logic [WIDTH:0]   C_THREE = (WIDTH + 1)'(3);
  localparam logic [SW-1:0]    C_NINE  = SW'(9);
  localparam logic [SW-1:0]    C_FOUR  = SW'(4);
  localparam logic [CW-1:0]    C_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAND,
    S_DIV,
    S_TEST,
    S_DONE,
    S_ERRH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   cand_q,  cand_d;
  logic [WIDTH:0]   div_q,   div_d;
  logic [SW-1:0]    sq_q,    sq_d;
  logic [WIDTH:0]   rem_q,   rem_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             err_q,   err_d;

  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic [SW-1:0]    sq_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      div_q   <= '0;
      sq_q    <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      sq_q    <= sq_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    div_d   = div_q;
    sq_d    = sq_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;

    rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    q_bit   = (rem_sh >= div_q);
    // (d+2)^2 = d^2 + 4d + 4: the next odd divisor's square, used both as the
    // stop test and as the updated square, so no multiplier is needed.
    sq_step = sq_q + (SW'(div_q) << 2) + C_FOUR;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          cand_d  = (seed < WIDTH'(2)) ? C_TWO : {1'b0, seed};
          state_d = S_CAND;
        end else if (go) begin
          if (err_q) begin
            state_d = S_ERRH;
          end else begin
            cand_d  = ({1'b0, res_q} + C_ONE < C_TWO) ? C_TWO : {1'b0, res_q} + C_ONE;
            state_d = S_CAND;
          end
        end
      end

      S_CAND: begin
        // All increments land here first, so the overflow check lives in one place.
        if (cand_q[WIDTH]) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cand_q == C_TWO || cand_q == C_THREE) begin
          state_d = S_DONE;
        end else if (!cand_q[0]) begin
          cand_d = cand_q + C_ONE;
        end else begin
          div_d   = C_THREE;
          sq_d    = C_NINE;
          rem_d   = '0;
          dvd_d   = cand_q[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        rem_d = q_bit ? (rem_sh - div_q) : rem_sh;
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_TEST;
        end
      end

      S_TEST: begin
        if (rem_q == '0) begin
          cand_d  = cand_q + C_TWO;
          state_d = S_CAND;
        end else if (sq_step > SW'(cand_q)) begin
          state_d = S_DONE;
        end else begin
          div_d   = div_q + C_TWO;
          sq_d    = sq_step;
          rem_d   = '0;
          dvd_d   = cand_q[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DONE: begin
        res_d   = cand_q[WIDTH-1:0];
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      S_ERRH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign error = err_q;
  assign res   = res_q;

endmodule

// File: tb/tb_primogen_param.sv
// Directed bench for primogen_param at WIDTH=16 and WIDTH=8, plus a 16-bit free run
// against a bench-side prime reference.
module tb_primogen_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, go16, ld16, rdy16, err16;
  logic [15:0] seed16, res16;
  logic        rst8, go8, ld8, rdy8, err8;
  logic [7:0]  seed8, res8;

  primogen_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst16), .go(go16), .load(ld16), .seed(seed16),
    .ready(rdy16), .error(err16), .res(res16)
  );

  primogen_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .go(go8), .load(ld8), .seed(seed8),
    .ready(rdy8), .error(err8), .res(res8)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_prime(input int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int unsigned next_prime(input int unsigned n);
    int unsigned m = n + 1;
    while (!is_prime(m)) m++;
    return m;
  endfunction

  task automatic wait16();
    int n = 0;
    while (!rdy16 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready16_bound", rdy16, 1);
  endtask

  task automatic wait8();
    int n = 0;
    while (!rdy8 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready8_bound", rdy8, 1);
  endtask

  // Called at #1 after an edge with ready high; pulses the request for one edge.
  task automatic req16(input logic ld, input logic g, input logic [15:0] s);
    ld16 = ld; go16 = g; seed16 = s;
    @(posedge clk); #1;
    ld16 = 1'b0; go16 = 1'b0; seed16 = 16'($urandom);
    wait16();
  endtask

  task automatic req8(input logic ld, input logic g, input logic [7:0] s);
    ld8 = ld; go8 = g; seed8 = s;
    @(posedge clk); #1;
    ld8 = 1'b0; go8 = 1'b0; seed8 = 8'($urandom);
    wait8();
  endtask

  int unsigned exp_seq [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
  int unsigned expp;
  int unsigned nprimes;
  logic        prev_rdy;

  initial begin
    rst16 = 1'b0; go16 = 1'b0; ld16 = 1'b0; seed16 = '0;
    rst8  = 1'b0; go8  = 1'b0; ld8  = 1'b0; seed8  = '0;
    @(posedge clk); #1;
    check("rst_ready", rdy16, 1);
    check("rst_res", res16, 0);
    check("rst_error", err16, 0);
    rst16 = 1'b1; rst8 = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      req16(1'b0, 1'b1, '0);
      check("seq_res", res16, exp_seq[i]);
      check("seq_error", err16, 0);
    end

    req16(1'b1, 1'b0, 16'd90);  check("load90", res16, 97);
    req16(1'b1, 1'b0, 16'd97);  check("load97", res16, 97);
    req16(1'b1, 1'b0, 16'd0);   check("load0", res16, 2);
    req16(1'b1, 1'b0, 16'd1);   check("load1", res16, 2);
    req16(1'b1, 1'b0, 16'd97);
    req16(1'b0, 1'b1, '0);      check("go_after97", res16, 101);
    req16(1'b1, 1'b1, 16'd50);  check("load_wins", res16, 53);

    // go pulse while busy must be dropped, not queued
    go16 = 1'b1;
    @(posedge clk); #1;
    go16 = 1'b0;
    @(posedge clk); #1;
    go16 = 1'b1;
    @(posedge clk); #1;
    go16 = 1'b0;
    wait16();
    check("busy_go_res", res16, 59);
    repeat (3) @(posedge clk);
    #1;
    check("busy_go_not_queued", rdy16, 1);
    check("busy_go_res_hold", res16, 59);

    // 8-bit overflow and sticky error
    req8(1'b1, 1'b0, 8'd250);  check("w8_load250", res8, 251); check("w8_load250_err", err8, 0);
    req8(1'b0, 1'b1, '0);      check("w8_ovf_err", err8, 1);   check("w8_ovf_res", res8, 251);
    req8(1'b0, 1'b1, '0);      check("w8_sticky_err", err8, 1); check("w8_sticky_res", res8, 251);
    req8(1'b1, 1'b0, 8'd3);    check("w8_load3", res8, 3);     check("w8_load3_err", err8, 0);
    req8(1'b1, 1'b0, 8'd252);  check("w8_load252_err", err8, 1); check("w8_load252_res", res8, 3);

    // Asynchronous reset in the middle of a trial division
    ld16 = 1'b1; seed16 = 16'd90;
    @(posedge clk); #1;
    ld16 = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("mid_busy", rdy16, 0);
    rst16 = 1'b0;
    #1;
    check("async_rst_ready", rdy16, 1);
    check("async_rst_res", res16, 0);
    check("async_rst_err", err16, 0);
    @(negedge clk);
    rst16 = 1'b1;
    @(posedge clk); #1;
    req16(1'b0, 1'b1, '0);     check("after_rst_go", res16, 2);

    // Free run with go held high
    rst16 = 1'b0;
    @(posedge clk); #1;
    rst16 = 1'b1;
    go16 = 1'b1;
    expp = 2;
    nprimes = 0;
    prev_rdy = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (rdy16 && !prev_rdy) begin
        check("free_res", res16, expp);
        check("free_err", err16, 0);
        expp = next_prime(expp);
        nprimes++;
      end
      prev_rdy = rdy16;
    end
    go16 = 1'b0;
    check("free_progress", (nprimes > 100) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
